// File: rtl/inst_mem_loader.sv
// Boot-time loader: packs a little-endian byte stream into INST_W-bit words and writes them
// to instruction memory from address 0, then releases the CPU. Option: INST_LOADER_CHECKSUM_EN.
module inst_mem_loader #(
    parameter int ADDR_W = 12,
    parameter int INST_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, B0, B1, B2, WR, CHK, FIN, ERR} state_t;

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t LAST = CHK;
`else
    localparam state_t LAST = FIN;
`endif

    // Bits of the third byte that lie above the instruction's top bit.
    localparam logic [7:0] HI_MASK = 8'(8'hFF << (INST_W - 16));

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] count, len;
    logic [15:0]       inst_lo;
    logic              xfer, hi_bad, more;

    assign in_ready = (state == B0) || (state == B1) || (state == B2) || (state == CHK);
    assign xfer     = in_valid & in_ready;
    assign hi_bad   = |(in_data & HI_MASK);
    assign more     = (count + ADDR_W'(1)) < len;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sum <= '0;
        else if (state == IDLE && load_req)
            sum <= '0;
        else if (xfer && state != CHK)
            sum <= sum + in_data;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_req) state_nxt = (load_len == '0) ? LAST : B0;
            B0:   if (xfer) state_nxt = B1;
            B1:   if (xfer) state_nxt = B2;
            B2:   if (xfer) state_nxt = hi_bad ? ERR : WR;
            WR:   state_nxt = more ? B0 : LAST;
`ifdef INST_LOADER_CHECKSUM_EN
            CHK:  if (xfer) state_nxt = (in_data == sum) ? FIN : ERR;
`else
            CHK:  state_nxt = IDLE;
`endif
            FIN:  state_nxt = IDLE;
            ERR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            len       <= '0;
            inst_lo   <= '0;
        end else begin
            mem_we    <= (state_nxt == WR);
            cpu_hold  <= (state_nxt == B0) || (state_nxt == B1) || (state_nxt == B2) ||
                         (state_nxt == WR) || (state_nxt == CHK);
            cpu_start <= (state_nxt == FIN);
            busy      <= (state_nxt != IDLE);
            if (state == IDLE && load_req) begin
                done  <= 1'b0;
                err   <= 1'b0;
                count <= '0;
                len   <= load_len;
            end
            if (state_nxt == FIN) done <= 1'b1;
            if (state_nxt == ERR) err  <= 1'b1;
            if (xfer) begin
                case (state)
                    B0: inst_lo[7:0]  <= in_data;
                    B1: inst_lo[15:8] <= in_data;
                    B2: if (!hi_bad) begin
                        mem_wdata <= {in_data[INST_W-17:0], inst_lo};
                        mem_addr  <= count;
                    end
                    default: ;
                endcase
            end
            if (state == WR) count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected writes are queued by the stimulus and
// popped by a negedge monitor on every mem_we. Define INST_LOADER_CHECKSUM_EN to cover the option.
module tb_inst_mem_loader;

    localparam int ADDR_W = 12;
    localparam int INST_W = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic [ADDR_W-1:0] load_len;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, cpu_hold, cpu_start, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   start_cnt = 0;
    logic hold_prev = 1'b0;
    logic hold_before_start = 1'b0;

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .cpu_start(cpu_start), .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mem_we) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                             mem_addr, mem_wdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.addr));
                    check("write_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (cpu_start) begin
                start_cnt++;
                hold_before_start = hold_prev;
                check("hold_low_at_start", 32'(cpu_hold), 32'd0);
            end
            hold_prev = cpu_hold;
        end
    end

    task automatic expect_write(input int a, input int d);
        exp_t e;
        e.addr = ADDR_W'(a);
        e.data = INST_W'(d);
        q.push_back(e);
    endtask

    task automatic load(input int len);
        load_req = 1'b1;
        load_len = ADDR_W'(len);
        @(posedge clk); #1;
        load_req = 1'b0;
        load_len = ADDR_W'($urandom);
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit chk_gap);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose for byte 0x%0h", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (chk_gap) check("gap_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_inst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int gap);
        send(b0, gap, 1'b1);
        send(b1, gap, 1'b1);
        send(b2, gap, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: busy stuck high", name);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int s0;
        rst      = 1'b0;
        load_req = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {in_ready, mem_we, cpu_hold, cpu_start, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: back-to-back bytes, two instructions
        s0 = start_cnt;
        expect_write(0, 'h51234);
        expect_write(1, 'h7FFFF);
        load(2);
        check("t1_hold", 32'(cpu_hold), 32'd1);
        send_inst(8'h34, 8'h12, 8'h05, 0);
        send_inst(8'hFF, 8'hFF, 8'h07, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h50, 0, 1'b0);
`endif
        wait_idle("t1");
        check("t1_writes_seen", 32'(q.size()), 32'd0);
        check("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t1_hold_before_start", 32'(hold_before_start), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // 2: same with 5-cycle stalls between bytes
        s0 = start_cnt;
        expect_write(0, 'h51234);
        expect_write(1, 'h7FFFF);
        load(2);
        send_inst(8'h34, 8'h12, 8'h05, 5);
        send_inst(8'hFF, 8'hFF, 8'h07, 5);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h50, 0, 1'b0);
`endif
        wait_idle("t2");
        check("t2_writes_seen", 32'(q.size()), 32'd0);
        check("t2_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t2_done", 32'(done), 32'd1);

        // 3: illegal upper bit in third byte aborts with no write
        s0 = start_cnt;
        load(1);
        send_inst(8'h00, 8'h00, 8'h08, 0);
        wait_idle("t3");
        check("t3_err", 32'(err), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_no_start", 32'(start_cnt - s0), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // 4: zero-length load
        s0 = start_cnt;
        load(0);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h00, 0, 1'b0);
`else
        @(negedge clk);
        check("t4_start_timing", 32'(cpu_start), 32'd1);
        @(posedge clk); #1;
`endif
        wait_idle("t4");
        check("t4_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_err", 32'(err), 32'd0);

        // 5: reset mid-load, then a fresh load
        s0 = start_cnt;
        expect_write(0, 'h00201);
        load(3);
        send_inst(8'h01, 8'h02, 8'h00, 0);
        send(8'h11, 0, 1'b0);
        check("t5_first_write_seen", 32'(q.size()), 32'd0);
        rst = 1'b0;
        #2;
        check("t5_reset_ctrl", {in_ready, mem_we, cpu_hold, cpu_start, busy, done, err}, 32'd0);
        check("t5_reset_addr", 32'(mem_addr), 32'd0);
        check("t5_reset_data", 32'(mem_wdata), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        expect_write(0, 'h055AA);
        load(1);
        send_inst(8'hAA, 8'h55, 8'h00, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'hFF, 0, 1'b0);
`endif
        wait_idle("t5");
        check("t5_writes_seen", 32'(q.size()), 32'd0);
        check("t5_start_pulses", 32'(start_cnt - s0), 32'd1);
        check("t5_done", 32'(done), 32'd1);

`ifdef INST_LOADER_CHECKSUM_EN
        // 6: checksum match and mismatch
        s0 = start_cnt;
        expect_write(0, 'h30201);
        load(1);
        send_inst(8'h01, 8'h02, 8'h03, 0);
        send(8'h06, 0, 1'b0);
        wait_idle("t6a");
        check("t6a_done", 32'(done), 32'd1);
        check("t6a_start_pulses", 32'(start_cnt - s0), 32'd1);
        s0 = start_cnt;
        expect_write(0, 'h30201);
        load(1);
        send_inst(8'h01, 8'h02, 8'h03, 0);
        send(8'h07, 0, 1'b0);
        wait_idle("t6b");
        check("t6b_err", 32'(err), 32'd1);
        check("t6b_done", 32'(done), 32'd0);
        check("t6b_no_start", 32'(start_cnt - s0), 32'd0);
        check("t6_writes_seen", 32'(q.size()), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
